fir_seq_ctrl: RTL and testbench
===============================

// Module: fir_seq_ctrl
// PURPOSE
//   Sequencer between a valid/ready sample stream and the FILTER FIR datapath.
//   Accepts one sample, pulses FILTER.ready, waits for the rising edge of Done,
//   captures FIR_output and presents it on a valid/ready result port.
//   Strictly one sample in flight. Counts completed samples for bench/status use.
// PARAMETERS
//   INPUT_WIDTH    16   sample width, matches FILTER FIR_input
//   OUTPUT_WIDTH   38   result width, matches FILTER FIR_output
//   COUNT_WIDTH    18   width of completed-sample counter
//   TIMEOUT_CYCLES 64   max WAIT cycles before abort (only with FIR_TIMEOUT_EN)
// PORTS
//   clk          in   1   single clock, all logic on posedge
//   rst          in   1   synchronous, active-low reset
//   s_valid      in   1   input sample valid
//   s_ready      out  1   controller can accept a sample
//   s_data       in   INPUT_WIDTH   input sample
//   fir_ready    out  1   start strobe to FILTER.ready
//   fir_input    out  INPUT_WIDTH   sample driven to FILTER.FIR_input
//   fir_output   in   OUTPUT_WIDTH  FILTER.FIR_output
//   fir_done     in   1   FILTER.Done
//   m_valid      out  1   result valid
//   m_ready      in   1   result consumer ready
//   m_data       out  OUTPUT_WIDTH  captured FIR result
//   busy         out  1   high in any state except IDLE
//   sample_cnt   out  COUNT_WIDTH   completed (consumed) results
//   timeout_err  out  1   sticky abort flag
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state=IDLE; fir_ready, m_valid, busy, timeout_err = 0;
//     fir_input, m_data, sample_cnt = 0; done_q = 0. Applies mid-operation; an in-flight
//     result is discarded (any Done edge outside WAIT is ignored).
//   - FSM: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
//     IDLE : s_ready=1. On s_valid&&s_ready: fir_input<=s_data, -> ISSUE.
//     ISSUE: fir_ready=1 for exactly this one cycle; -> WAIT.
//     WAIT : done_rise = fir_done & ~done_q. On done_rise: m_data<=fir_output,
//            m_valid<=1, -> HOLD. Done already high on WAIT entry does not count.
//     HOLD : m_valid held, m_data stable. On m_valid&&m_ready: m_valid<=0,
//            sample_cnt<=sample_cnt+1, -> IDLE.
//   - s_ready is 0 outside IDLE; no sample accepted in the same cycle a result is consumed.
//   - done_q registers fir_done every cycle, all states.
//   - Latency: accept edge N -> fir_ready high cycle N+1 -> m_valid high the cycle after
//     the edge sampling done_rise. Min accept-to-accept = 4 cycles + FIR latency.
//   - fir_input holds its value until the next accept.
//   - sample_cnt wraps modulo 2^COUNT_WIDTH; no saturation.
//   - Widths passed through unchanged; no arithmetic on data.
// CONFIGURATION
//   FIR_TIMEOUT_EN defined: WAIT counter reset on WAIT entry; if it reaches TIMEOUT_CYCLES
//     with no done_rise, timeout_err<=1 (sticky until reset), m_valid stays 0,
//     sample_cnt unchanged, -> IDLE. done_rise in the same cycle as expiry wins (normal path).
//   FIR_TIMEOUT_EN undefined: WAIT waits indefinitely; timeout_err tied 0; no counter logic.
// STRUCTURE
//   - Package fir_ctrl_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, HOLD=3),
//     default width constants (16/38/18), TIMEOUT_CYCLES default.
//   - Sub-module fir_done_watch: done_q register, done_rise output, and (under
//     FIR_TIMEOUT_EN) the WAIT timeout counter with an expired output.
// TESTING
//   1. Reset release, s_data=16'd100 valid for 1 cycle, FIR model Done rises 5 cycles after
//      ready, m_ready=1 -> one fir_ready pulse, m_data==model(100), sample_cnt==1.
//   2. m_ready=0 for 10 cycles in HOLD -> m_valid/m_data stable, s_ready=0, no second
//      fir_ready; m_ready=1 -> sample_cnt increments once.
//   3. Back-to-back s_valid=1 with 8 samples -> exactly 8 fir_ready pulses, no overlap,
//      results in order, sample_cnt==8.
//   4. Done held high across ISSUE into WAIT, then low, then high -> result captured only
//      on the second rise.
//   5. rst=0 for one edge during WAIT, then Done rises -> no m_valid, state IDLE,
//      sample_cnt==0.
//   6. FIR_TIMEOUT_EN, TIMEOUT_CYCLES=64, Done never rises -> timeout_err=1 after 64 WAIT
//      cycles, IDLE, s_ready=1; next sample with Done completes normally, timeout_err stays 1.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared definitions for the FIR sequencer.
//   state_t          - sequencer FSM encoding (IDLE=0, ISSUE=1, WAIT=2, HOLD=3)
//   *_DEF constants  - default sample/result/counter widths and WAIT timeout
package fir_ctrl_pkg;

  localparam int INPUT_WIDTH_DEF    = 16;
  localparam int OUTPUT_WIDTH_DEF   = 38;
  localparam int COUNT_WIDTH_DEF    = 18;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: generic valid/ready stream carrying W-bit data.
//   valid, data - driven by the producer (master)
//   ready       - driven by the consumer (slave)
interface fir_seq_ctrl_if
  import fir_ctrl_pkg::*;
#(
  parameter int W = INPUT_WIDTH_DEF
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_done_watch.sv
// fir_done_watch: edge detector on FILTER.Done plus optional WAIT watchdog.
//   clk, rst  - clock, synchronous active-low reset
//   fir_done  - FILTER.Done
//   in_wait   - sequencer is in WAIT this cycle
//   done_rise - fir_done high now and low last cycle
//   expired   - current cycle is the TIMEOUT_CYCLES-th WAIT cycle
// Build option: FIR_TIMEOUT_EN enables the watchdog; otherwise expired is 0
// and no counter exists.
module fir_done_watch
  import fir_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fir_done,
  input  logic in_wait,
  output logic done_rise,
  output logic expired
);

  logic done_q;

  // Sampled in every state so a Done already high on WAIT entry is not an edge.
  always_ff @(posedge clk) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= fir_done;
  end

  assign done_rise = fir_done & ~done_q;

`ifdef FIR_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wait_cnt;

  // Held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst || !in_wait) wait_cnt <= '0;
    else                  wait_cnt <= wait_cnt + 1'b1;
  end

  assign expired = in_wait && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_in_wait;
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign unused_in_wait = in_wait;
  assign expired        = 1'b0;
`endif

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: one-sample-in-flight sequencer between a sample stream and
// the FILTER FIR datapath. Accepts a sample, strobes fir_ready for one cycle,
// waits for a rising edge on fir_done, then holds the captured result on the
// result stream until consumed.
//   clk, rst    - clock, synchronous active-low reset
//   s_if        - sample stream in (slave): valid/ready/data[INPUT_WIDTH]
//   m_if        - result stream out (master): valid/ready/data[OUTPUT_WIDTH]
//   fir_ready   - start strobe to FILTER
//   fir_input   - sample presented to FILTER, held until the next accept
//   fir_output  - FILTER result
//   fir_done    - FILTER completion flag
//   busy        - any state other than IDLE
//   sample_cnt  - consumed results, wraps
//   timeout_err - sticky WAIT abort flag
// Build option: FIR_TIMEOUT_EN aborts WAIT after TIMEOUT_CYCLES cycles
// without a Done edge; without it timeout_err is tied low.
module fir_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int INPUT_WIDTH    = INPUT_WIDTH_DEF,
  parameter int OUTPUT_WIDTH   = OUTPUT_WIDTH_DEF,
  parameter int COUNT_WIDTH    = COUNT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_seq_ctrl_if.slave           s_if,
  fir_seq_ctrl_if.master          m_if,
  output logic                    fir_ready,
  output logic [INPUT_WIDTH-1:0]  fir_input,
  input  logic [OUTPUT_WIDTH-1:0] fir_output,
  input  logic                    fir_done,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  sample_cnt,
  output logic                    timeout_err
);

  state_t                  state, state_nxt;
  logic                    s_ready;
  logic                    accept, capture, consume, abort;
  logic                    done_rise, expired;
  logic                    m_valid;
  logic [OUTPUT_WIDTH-1:0] m_data;

  fir_done_watch #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watch (
    .clk       (clk),
    .rst       (rst),
    .fir_done  (fir_done),
    .in_wait   (state == WAIT),
    .done_rise (done_rise),
    .expired   (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    fir_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    consume   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_if.valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        fir_ready = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A Done edge on the expiry cycle still delivers the result.
        if (done_rise) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (m_valid && m_if.ready) begin
          consume   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fir_input  <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (accept)  fir_input <= s_if.data;
      if (capture) begin
        m_data  <= fir_output;
        m_valid <= 1'b1;
      end
      if (consume) begin
        m_valid    <= 1'b0;
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

`ifdef FIR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst)       timeout_err <= 1'b0;
    else if (abort) timeout_err <= 1'b1;
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign timeout_err  = 1'b0;
`endif

  assign s_if.ready = s_ready;
  assign m_if.valid = m_valid;
  assign m_if.data  = m_data;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;
  import fir_ctrl_pkg::*;

  localparam int IW = 16;
  localparam int OW = 38;
  localparam int CW = 18;
  localparam logic [OW-1:0] JUNK = 38'h15_5555_5555;

  logic          clk, rst;
  logic          fir_ready;
  logic [IW-1:0] fir_input;
  logic [OW-1:0] fir_output;
  logic          fir_done;
  logic          busy;
  logic [CW-1:0] sample_cnt;
  logic          timeout_err;

  fir_seq_ctrl_if #(.W(IW)) s_if ();
  fir_seq_ctrl_if #(.W(OW)) m_if ();

  fir_seq_ctrl #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if),
    .m_if        (m_if),
    .fir_ready   (fir_ready),
    .fir_input   (fir_input),
    .fir_output  (fir_output),
    .fir_done    (fir_done),
    .busy        (busy),
    .sample_cnt  (sample_cnt),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0, pulses = 0, accepts = 0;
  logic [OW-1:0] sb_q[$];
  logic [OW-1:0] sb_e;

  // FILTER stand-in: fixed transform of the presented sample; junk while Done low
  function automatic logic [OW-1:0] fir_model(input logic [IW-1:0] x);
    logic [OW-1:0] t;
    t = {{(OW-IW){x[IW-1]}}, x};
    return (t << 5) + 38'h2_0000_1234;
  endfunction

  logic model_en, man_done;
  logic mdl_done = 1'b0;
  int   cd = 0;
  assign fir_done   = model_en ? mdl_done : man_done;
  assign fir_output = fir_done ? fir_model(fir_input) : JUNK;

  // Done pulses for one cycle, 5 cycles after the ready strobe
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (fir_ready) cd = 5;
    else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) mdl_done = 1'b1;
    end
  end

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic checkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer and ready-pulse counter
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1) begin
      if (fir_ready) pulses++;
      if (m_if.valid && m_if.ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got result %0h want none", m_if.data);
        end else begin
          sb_e = sb_q.pop_front();
          checkw("sb_data", 64'(m_if.data), 64'(sb_e));
        end
      end
    end
  end

  typedef struct {
    logic [IW-1:0] data;
    int            stall;
    bit            keep;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t          vt[10];
  logic [IW-1:0] dv[10] = '{16'd100, 16'h1234, 16'h0000, 16'hFFFF, 16'h0001,
                            16'h8000, 16'h7FFF, 16'h00FF, 16'hA5A5, 16'd42};

  initial begin
    int n, errs;
    logic [OW-1:0] md;

    rst = 1'b0; s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b1;
    model_en = 1'b1; man_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vt[i].data  = dv[i];
      vt[i].stall = (i == 1) ? 10 : 0;
      vt[i].keep  = (i != 0);
      vt[i].exp   = fir_model(dv[i]);
    end

    repeat (3) @(negedge clk);
    check1("rst_s_ready", s_if.ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_m_valid", m_if.valid, 1'b0);
    check1("rst_fir_ready", fir_ready, 1'b0);
    check1("rst_timeout", timeout_err, 1'b0);
    checkw("rst_cnt", 64'(sample_cnt), 64'd0);
    checkw("rst_m_data", 64'(m_if.data), 64'd0);
    checkw("rst_fir_input", 64'(fir_input), 64'd0);
    rst = 1'b1;

    // Tests 1-3: single sample, HOLD stall, back-to-back stream
    for (int i = 0; i < 10; i++) begin
      s_if.data  = vt[i].data;
      s_if.valid = 1'b1;
      m_if.ready = (vt[i].stall == 0);
      n = 0;
      while (!s_if.ready && n < 50) begin @(negedge clk); n++; end
      check1("accept_ready", s_if.ready, 1'b1);
      sb_q.push_back(vt[i].exp);
      accepts++;
      @(negedge clk);
      if (!vt[i].keep) s_if.valid = 1'b0;
      check1("issue_fir_ready", fir_ready, 1'b1);
      check1("issue_s_ready", s_if.ready, 1'b0);
      check1("issue_busy", busy, 1'b1);
      checkw("fir_input", 64'(fir_input), 64'(vt[i].data));
      @(negedge clk);
      n = 1;
      check1("wait_fir_ready", fir_ready, 1'b0);
      while (!m_if.valid && n < 100) begin @(negedge clk); n++; end
      checkw("latency", 64'(n), 64'd6);
      if (vt[i].stall > 0) begin
        md = m_if.data;
        repeat (vt[i].stall) begin
          @(negedge clk);
          check1("stall_valid", m_if.valid, 1'b1);
          checkw("stall_data", 64'(m_if.data), 64'(md));
          check1("stall_s_ready", s_if.ready, 1'b0);
          check1("stall_fir_ready", fir_ready, 1'b0);
        end
        m_if.ready = 1'b1;
      end
      @(negedge clk);
      checkw("sample_cnt", 64'(sample_cnt), 64'(i + 1));
      check1("idle_s_ready", s_if.ready, 1'b1);
      check1("idle_m_valid", m_if.valid, 1'b0);
      if (i == 0) checkw("t1_pulses", 64'(pulses), 64'd1);
    end
    s_if.valid = 1'b0;
    checkw("t3_pulses", 64'(pulses), 64'd10);

    // Test 4: Done high across ISSUE into WAIT; only the later rise counts
    model_en = 1'b0; man_done = 1'b1;
    s_if.data = 16'd55; s_if.valid = 1'b1;
    sb_q.push_back(fir_model(16'd55));
    accepts++;
    @(negedge clk);
    s_if.valid = 1'b0;
    check1("t4_issue", fir_ready, 1'b1);
    repeat (3) begin @(negedge clk); check1("t4_high_no_capture", m_if.valid, 1'b0); end
    man_done = 1'b0;
    repeat (2) begin @(negedge clk); check1("t4_low_no_capture", m_if.valid, 1'b0); end
    man_done = 1'b1;
    @(negedge clk);
    check1("t4_capture", m_if.valid, 1'b1);
    checkw("t4_data", 64'(m_if.data), 64'(fir_model(16'd55)));
    man_done = 1'b0;
    @(negedge clk);
    checkw("t4_cnt", 64'(sample_cnt), 64'd11);
    model_en = 1'b1;

    // Test 5: reset during WAIT, Done later rises in IDLE
    s_if.data = 16'd77; s_if.valid = 1'b1;
    accepts++;
    @(negedge clk);
    s_if.valid = 1'b0;
    check1("t5_issue", fir_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check1("t5_busy", busy, 1'b0);
    check1("t5_s_ready", s_if.ready, 1'b1);
    checkw("t5_cnt", 64'(sample_cnt), 64'd0);
    checkw("t5_fir_input", 64'(fir_input), 64'd0);
    checkw("t5_m_data", 64'(m_if.data), 64'd0);
    repeat (8) begin
      @(negedge clk);
      check1("t5_no_valid", m_if.valid, 1'b0);
      check1("t5_idle", busy, 1'b0);
    end

`ifdef FIR_TIMEOUT_EN
    // Test 6: Done never rises -> abort after 64 WAIT cycles, flag sticky
    model_en = 1'b0; man_done = 1'b0;
    s_if.data = 16'd9; s_if.valid = 1'b1;
    accepts++;
    @(negedge clk);
    s_if.valid = 1'b0;
    check1("t6_issue", fir_ready, 1'b1);
    errs = 0;
    repeat (64) begin
      @(negedge clk);
      if (!busy || timeout_err) errs++;
    end
    checkw("t6_wait_cycles_bad", 64'(errs), 64'd0);
    @(negedge clk);
    check1("t6_timeout", timeout_err, 1'b1);
    check1("t6_s_ready", s_if.ready, 1'b1);
    check1("t6_m_valid", m_if.valid, 1'b0);
    checkw("t6_cnt", 64'(sample_cnt), 64'd0);
    model_en = 1'b1;
    s_if.data = 16'd200; s_if.valid = 1'b1;
    sb_q.push_back(fir_model(16'd200));
    accepts++;
    @(negedge clk);
    s_if.valid = 1'b0;
    n = 0;
    while (!m_if.valid && n < 100) begin @(negedge clk); n++; end
    check1("t6_done_valid", m_if.valid, 1'b1);
    @(negedge clk);
    checkw("t6_cnt_after", 64'(sample_cnt), 64'd1);
    check1("t6_sticky", timeout_err, 1'b1);
`else
    // Without the watchdog WAIT holds indefinitely
    model_en = 1'b0; man_done = 1'b0;
    s_if.data = 16'd9; s_if.valid = 1'b1;
    sb_q.push_back(fir_model(16'd9));
    accepts++;
    @(negedge clk);
    s_if.valid = 1'b0;
    repeat (100) @(negedge clk);
    check1("long_wait_busy", busy, 1'b1);
    check1("long_wait_timeout", timeout_err, 1'b0);
    check1("long_wait_m_valid", m_if.valid, 1'b0);
    man_done = 1'b1;
    @(negedge clk);
    check1("long_wait_capture", m_if.valid, 1'b1);
    man_done = 1'b0;
    @(negedge clk);
    checkw("long_wait_cnt", 64'(sample_cnt), 64'd1);
    check1("long_wait_timeout_end", timeout_err, 1'b0);
    model_en = 1'b1;
`endif

    repeat (2) @(negedge clk);
    checkw("sb_empty", 64'(sb_q.size()), 64'd0);
    checkw("pulses_vs_accepts", 64'(pulses), 64'(accepts));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
